load_unit: RTL and testbench
============================

LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, max DATA-state cycles waiting for bus_rvalid before access error (legal 2..65535).
REQ-002 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: req_valid in 1 load request; req_ready out 1 unit can accept; req_addr in 32 byte address; req_size in 3 load size ([1:0] 00 byte/01 half/10 word/11 invalid, [2] 1=zero-extend).
REQ-005 SHALL have ports: resp_valid out 1 result valid; resp_ready in 1 consumer accepts; resp_data out 32 extended load data; resp_misalign out 1 misaligned/invalid-size fault; resp_err out 1 bus error or timeout.
REQ-006 SHALL have ports: bus_req out 1 read request; bus_gnt in 1 request accepted; bus_addr out 32 word address; bus_lanes out 4 byte lanes read; bus_rvalid in 1 read data valid; bus_rdata in 32 read word; bus_rerr in 1 read error, qualified by bus_rvalid.

Function
REQ-007 SHALL implement FSM states IDLE, ADDR, DATA, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL, in IDLE with req_valid=1, register req_addr and req_size; next state ADDR if aligned and size legal, else RESP with resp_misalign=1, resp_data=0, no bus access.
REQ-009 SHALL define alignment: byte any offset; half offset 0 or 2; word offset 0; size 11 always faults.
REQ-010 SHALL in ADDR drive bus_req=1, bus_addr={addr[31:2],2'b00}, bus_lanes = byte 0001<<off, half 0011 (off 0)/1100 (off 2), word 1111; hold all stable until bus_gnt.
REQ-011 SHALL in ADDR with bus_gnt=1 move to DATA and clear timeout counter; bus_req=0 and bus_lanes=0 outside ADDR.
REQ-012 SHALL ignore bus_rvalid in IDLE, ADDR and RESP.
REQ-013 SHALL in DATA with bus_rvalid=1 move to RESP: bus_rerr=0 -> resp_data=extracted value, resp_err=0; bus_rerr=1 -> resp_data=0, resp_err=1.
REQ-014 SHALL extract: byte bus_rdata[8*off+7:8*off]; half off 0 [15:0], off 2 [31:16]; word [31:0]; upper bits copy the field MSB when req_size[2]=0, zero when 1.
REQ-015 SHALL in DATA count cycles without bus_rvalid; counter reaching TIMEOUT-1 with no bus_rvalid -> RESP, resp_err=1, resp_data=0; bus_rvalid on that same cycle wins over timeout.
REQ-016 SHALL in RESP hold resp_valid=1 and all resp_* stable until resp_ready=1, then go IDLE; no new request accepted in the RESP-exit cycle (no IDLE bypass).
REQ-017 SHALL give minimum latency of 3 cycles: accept at t, bus_req at t+1 (gnt at t+1), rvalid at t+2, resp_valid at t+3; misaligned fault resp_valid at t+1.
REQ-018 SHALL drive resp_misalign and resp_err never both 1; resp_valid=0 outside RESP.

Reset
REQ-019 SHALL on rst_n=0 asynchronously enter IDLE: req_ready=1 after reset release; resp_valid, resp_data, resp_misalign, resp_err, bus_req, bus_addr, bus_lanes, timeout counter all 0.
REQ-020 SHALL on reset mid-transaction abandon it without response; late bus_rvalid after reset ignored per REQ-012.

Verification
REQ-021 SHALL cover: LB addr 0x103, bus_rdata 0x80FF_1234, immediate gnt/rvalid -> bus_lanes 1000, bus_addr 0x100, resp_data 0xFFFF_FF80 at t+3; LBU same -> 0x0000_0080.
REQ-022 SHALL cover: LH addr 0x202 rdata 0x9ABC_5678 -> lanes 1100, resp_data 0xFFFF_9ABC; LHU -> 0x0000_9ABC; LW addr 0x204 -> 0x9ABC_5678.
REQ-023 SHALL cover: LW addr 0x301, then LH addr 0x301, then size 011 -> resp_misalign=1, resp_data 0, bus_req never asserted, resp_valid at t+1.
REQ-024 SHALL cover: gnt delayed 3 cycles, rvalid delayed 5, resp_ready low 4 cycles -> bus_req/addr/lanes and resp_* stable throughout, req_ready=0 until RESP exit.
REQ-025 SHALL cover: TIMEOUT=16, no rvalid -> resp_err=1 after exactly 16 DATA cycles; rvalid with bus_rerr=1 -> resp_err=1, resp_data 0; rvalid on timeout cycle -> good data.
REQ-026 SHALL cover: rst_n pulsed low in DATA -> outputs zero immediately, stray rvalid afterwards produces no resp_valid, next LW completes normally.

Source files
------------

// File: rtl/load_unit_if.sv
// Load unit signal bundle: request, response and memory-bus channels.
// The slave modport is the load unit itself; master is the surrounding core/bus side.
interface load_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_size;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_misalign;
   logic        resp_err;

   logic        bus_req;
   logic        bus_gnt;
   logic [31:0] bus_addr;
   logic [3:0]  bus_lanes;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic        bus_rerr;

   modport slave (
      input  req_valid, req_addr, req_size, resp_ready,
             bus_gnt, bus_rvalid, bus_rdata, bus_rerr,
      output req_ready, resp_valid, resp_data, resp_misalign, resp_err,
             bus_req, bus_addr, bus_lanes
   );

   modport master (
      output req_valid, req_addr, req_size, resp_ready,
             bus_gnt, bus_rvalid, bus_rdata, bus_rerr,
      input  req_ready, resp_valid, resp_data, resp_misalign, resp_err,
             bus_req, bus_addr, bus_lanes
   );
endinterface

// File: rtl/load_unit.sv
// Single-outstanding load unit: alignment check, word-bus read with timeout,
// byte/half/word extraction with sign or zero extension.
module load_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   load_unit_if.slave lu
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t      state_reg, state_next;
   logic [31:0] addr_reg;
   logic [2:0]  size_reg;
   logic [15:0] cnt_reg;
   logic [31:0] data_reg;
   logic        misalign_reg;
   logic        err_reg;

   logic        req_aligned;
   logic        timeout_hit;
   logic [1:0]  off;
   logic [2:0]  nbytes;
   logic [3:0]  lanes;
   logic [31:0] shifted;
   logic [31:0] extracted;
   logic        sx;

   assign off         = addr_reg[1:0];
   assign timeout_hit = (cnt_reg == 16'(TIMEOUT - 1));
   assign sx          = ~size_reg[2];

   always_comb begin
      req_aligned = 1'b0;
      case (lu.req_size[1:0])
         2'b00:   req_aligned = 1'b1;
         2'b01:   req_aligned = ~lu.req_addr[0];
         2'b10:   req_aligned = (lu.req_addr[1:0] == 2'b00);
         default: req_aligned = 1'b0;
      endcase
   end

   always_comb begin
      nbytes = 3'd4;
      case (size_reg[1:0])
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   end

   // A lane is read when it falls inside [off, off+nbytes).
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign lanes[gi] = (3'(gi) >= {1'b0, off}) && (3'(gi) < ({1'b0, off} + nbytes));
      end
   endgenerate

   always_comb begin
      shifted   = lu.bus_rdata >> {off, 3'b000};
      extracted = shifted;
      case (size_reg[1:0])
         2'b00:   extracted = {{24{sx & shifted[7]}}, shifted[7:0]};
         2'b01:   extracted = {{16{sx & shifted[15]}}, shifted[15:0]};
         default: extracted = lu.bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (lu.req_valid) state_next = req_aligned ? ADDR : RESP;
         ADDR: if (lu.bus_gnt) state_next = DATA;
         DATA: if (lu.bus_rvalid || timeout_hit) state_next = RESP;
         RESP: if (lu.resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg     <= '0;
         size_reg     <= '0;
         cnt_reg      <= '0;
         data_reg     <= '0;
         misalign_reg <= 1'b0;
         err_reg      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (lu.req_valid) begin
               addr_reg     <= lu.req_addr;
               size_reg     <= lu.req_size;
               misalign_reg <= ~req_aligned;
               err_reg      <= 1'b0;
               data_reg     <= '0;
            end
            ADDR: if (lu.bus_gnt) cnt_reg <= '0;
            DATA: begin
               // Data arriving on the final counted cycle takes priority over the timeout.
               if (lu.bus_rvalid) begin
                  err_reg  <= lu.bus_rerr;
                  data_reg <= lu.bus_rerr ? 32'd0 : extracted;
               end else if (timeout_hit) begin
                  err_reg  <= 1'b1;
                  data_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      lu.req_ready     = 1'b0;
      lu.resp_valid    = 1'b0;
      lu.resp_data     = '0;
      lu.resp_misalign = 1'b0;
      lu.resp_err      = 1'b0;
      lu.bus_req       = 1'b0;
      lu.bus_addr      = '0;
      lu.bus_lanes     = '0;
      case (state_reg)
         IDLE: lu.req_ready = 1'b1;
         ADDR: begin
            lu.bus_req   = 1'b1;
            lu.bus_addr  = {addr_reg[31:2], 2'b00};
            lu.bus_lanes = lanes;
         end
         RESP: begin
            lu.resp_valid    = 1'b1;
            lu.resp_data     = data_reg;
            lu.resp_misalign = misalign_reg;
            lu.resp_err      = err_reg;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed vector table, reset-in-flight
// sequence and randomized loads checked against an arithmetic reference model.
module tb_load_unit;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   load_unit_if lu();
   load_unit #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .lu(lu));

   typedef struct {
      int          lat;
      logic [31:0] data;
      logic        mis;
      logic        err;
      logic        bus;
      logic [3:0]  lanes;
      logic [31:0] baddr;
      int          dcyc;
   } exp_t;

   typedef struct {
      int          lat;
      logic [31:0] data;
      logic        mis;
      logic        err;
      logic        bus;
      logic [3:0]  lanes;
      logic [31:0] baddr;
      int          dcyc;
      bit          stable;
      bit          busy_ok;
      logic        ready_after;
      bit          done;
   } obs_t;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [31:0] rdata;
      logic        rerr;
      int          gnt_dly;
      int          rv_dly;
      int          rdy_dly;
      exp_t        e;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
      end
   endtask

   // Reference model: derived from size/alignment rules with plain arithmetic.
   function automatic exp_t model(input logic [31:0] addr, input logic [2:0] size,
                                  input logic [31:0] rdata, input logic rerr,
                                  input int gnt_dly, input int rv_dly);
      exp_t   e;
      longint nb, off, a, field, span;
      bit     timed_out;
      e = '{lat: 1, data: 32'd0, mis: 1'b0, err: 1'b0, bus: 1'b0,
            lanes: 4'd0, baddr: 32'd0, dcyc: 0};
      a  = longint'({32'd0, addr});
      nb = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : (size[1:0] == 2'b10) ? 4 : 0;
      if (nb == 0 || (a % nb) != 0) begin
         e.mis = 1'b1;
         return e;
      end
      off       = a % 4;
      e.bus     = 1'b1;
      e.baddr   = 32'(a - off);
      e.lanes   = 4'(((64'd1 << nb) - 1) << off);
      timed_out = (rv_dly < 0) || (rv_dly >= TIMEOUT);
      e.dcyc    = timed_out ? TIMEOUT : rv_dly + 1;
      e.lat     = 1 + (gnt_dly + 1) + e.dcyc;
      if (timed_out || rerr) begin
         e.err = 1'b1;
      end else begin
         span  = 64'd1 << (8 * nb);
         field = (longint'({32'd0, rdata}) / (64'd1 << (8 * off))) % span;
         if (!size[2] && field >= span / 2) field = field + (64'h1_0000_0000 - span);
         e.data = 32'(field);
      end
      return e;
   endfunction

   task automatic idle_inputs();
      lu.req_valid  = 1'b0;
      lu.req_addr   = '0;
      lu.req_size   = '0;
      lu.resp_ready = 1'b0;
      lu.bus_gnt    = 1'b0;
      lu.bus_rvalid = 1'b0;
      lu.bus_rdata  = '0;
      lu.bus_rerr   = 1'b0;
   endtask

   task automatic run_txn(input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] rdata, input logic rerr,
                          input int gnt_dly, input int rv_dly, input int rdy_dly,
                          input bit noise, output obs_t o);
      int cyc, acyc, dcyc, rcyc;
      bit granted;
      o = '{lat: -1, data: 32'd0, mis: 1'b0, err: 1'b0, bus: 1'b0, lanes: 4'd0,
            baddr: 32'd0, dcyc: 0, stable: 1'b1, busy_ok: 1'b1, ready_after: 1'b0, done: 1'b0};
      if (lu.req_ready !== 1'b1) o.busy_ok = 1'b0;
      lu.req_valid = 1'b1;
      lu.req_addr  = addr;
      lu.req_size  = size;
      @(posedge clk); #1;
      lu.req_valid = 1'b0;
      lu.req_addr  = $urandom;
      lu.req_size  = 3'($urandom);
      cyc = 1; acyc = 0; dcyc = 0; rcyc = 0; granted = 1'b0;
      while (!o.done && cyc < 200) begin
         lu.bus_gnt    = 1'b0;
         lu.bus_rvalid = 1'b0;
         lu.bus_rerr   = 1'($urandom);
         lu.bus_rdata  = $urandom;
         lu.resp_ready = 1'b0;
         if (lu.req_ready !== 1'b0) o.busy_ok = 1'b0;
         if (lu.resp_valid === 1'b1) begin
            if (rcyc == 0) begin
               o.lat  = cyc;
               o.data = lu.resp_data;
               o.mis  = lu.resp_misalign;
               o.err  = lu.resp_err;
            end else if (lu.resp_data !== o.data || lu.resp_misalign !== o.mis ||
                         lu.resp_err !== o.err) begin
               o.stable = 1'b0;
            end
            if (lu.bus_req !== 1'b0) o.stable = 1'b0;
            if (noise) lu.bus_rvalid = 1'($urandom);
            if (rcyc == rdy_dly) begin
               lu.resp_ready = 1'b1;
               // A request offered in the exit cycle must not be taken.
               lu.req_valid  = 1'b1;
               lu.req_addr   = 32'h0000_0700;
               lu.req_size   = 3'b010;
               o.done        = 1'b1;
            end
            rcyc++;
         end else if (lu.bus_req === 1'b1) begin
            if (acyc == 0) begin
               o.bus   = 1'b1;
               o.baddr = lu.bus_addr;
               o.lanes = lu.bus_lanes;
            end else if (lu.bus_addr !== o.baddr || lu.bus_lanes !== o.lanes) begin
               o.stable = 1'b0;
            end
            if (noise) lu.bus_rvalid = 1'($urandom);
            if (acyc == gnt_dly) begin
               lu.bus_gnt = 1'b1;
               granted    = 1'b1;
            end
            acyc++;
         end else if (granted) begin
            if (rv_dly >= 0 && dcyc == rv_dly) begin
               lu.bus_rvalid = 1'b1;
               lu.bus_rdata  = rdata;
               lu.bus_rerr   = rerr;
            end
            dcyc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      idle_inputs();
      o.dcyc        = dcyc;
      o.ready_after = lu.req_ready;
   endtask

   task automatic compare(input string tag, input obs_t o, input exp_t e);
      check({tag, ".done"},    32'(o.done), 32'd1);
      check({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
      check({tag, ".data"},    o.data, e.data);
      check({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
      check({tag, ".err"},     32'(o.err), 32'(e.err));
      check({tag, ".bus_req_seen"}, 32'(o.bus), 32'(e.bus));
      check({tag, ".lanes"},   32'(o.lanes), 32'(e.lanes));
      check({tag, ".bus_addr"}, o.baddr, e.baddr);
      check({tag, ".data_cycles"}, 32'(o.dcyc), 32'(e.dcyc));
      check({tag, ".stable"},  32'(o.stable), 32'd1);
      check({tag, ".req_ready_low"}, 32'(o.busy_ok), 32'd1);
      check({tag, ".req_ready_after"}, 32'(o.ready_after), 32'd1);
   endtask

   vec_t vecs[12];

   initial begin
      obs_t o;
      exp_t e;
      bit   quiet;
      idle_inputs();

      //            addr          size    rdata          rerr gnt rv  rdy   lat data           mis err bus lanes baddr         dcyc
      vecs[0]  = '{32'h103, 3'b000, 32'h80FF_1234, 1'b0, 0, 0, 0, '{3,  32'hFFFF_FF80, 0, 0, 1, 4'b1000, 32'h100, 1}};
      vecs[1]  = '{32'h103, 3'b100, 32'h80FF_1234, 1'b0, 0, 0, 0, '{3,  32'h0000_0080, 0, 0, 1, 4'b1000, 32'h100, 1}};
      vecs[2]  = '{32'h202, 3'b001, 32'h9ABC_5678, 1'b0, 0, 0, 0, '{3,  32'hFFFF_9ABC, 0, 0, 1, 4'b1100, 32'h200, 1}};
      vecs[3]  = '{32'h202, 3'b101, 32'h9ABC_5678, 1'b0, 0, 0, 0, '{3,  32'h0000_9ABC, 0, 0, 1, 4'b1100, 32'h200, 1}};
      vecs[4]  = '{32'h204, 3'b010, 32'h9ABC_5678, 1'b0, 0, 0, 0, '{3,  32'h9ABC_5678, 0, 0, 1, 4'b1111, 32'h204, 1}};
      vecs[5]  = '{32'h301, 3'b010, 32'h9ABC_5678, 1'b0, 0, 0, 0, '{1,  32'h0,         1, 0, 0, 4'b0000, 32'h0,   0}};
      vecs[6]  = '{32'h301, 3'b001, 32'h9ABC_5678, 1'b0, 0, 0, 0, '{1,  32'h0,         1, 0, 0, 4'b0000, 32'h0,   0}};
      vecs[7]  = '{32'h300, 3'b011, 32'h9ABC_5678, 1'b0, 0, 0, 0, '{1,  32'h0,         1, 0, 0, 4'b0000, 32'h0,   0}};
      vecs[8]  = '{32'h400, 3'b010, 32'h1234_5678, 1'b0, 3, 5, 4, '{11, 32'h1234_5678, 0, 0, 1, 4'b1111, 32'h400, 6}};
      vecs[9]  = '{32'h500, 3'b010, 32'h1234_5678, 1'b0, 0, -1, 0, '{18, 32'h0,        0, 1, 1, 4'b1111, 32'h500, 16}};
      vecs[10] = '{32'h501, 3'b000, 32'h1234_5678, 1'b1, 0, 0, 0, '{3,  32'h0,         0, 1, 1, 4'b0010, 32'h500, 1}};
      vecs[11] = '{32'h502, 3'b001, 32'h8000_1111, 1'b0, 0, 15, 0, '{18, 32'hFFFF_8000, 0, 0, 1, 4'b1100, 32'h500, 16}};

      // Reset state, sampled while reset is still applied
      repeat (2) @(posedge clk);
      #1;
      check("rst.resp_valid", 32'(lu.resp_valid), 32'd0);
      check("rst.resp_data", lu.resp_data, 32'd0);
      check("rst.resp_misalign", 32'(lu.resp_misalign), 32'd0);
      check("rst.resp_err", 32'(lu.resp_err), 32'd0);
      check("rst.bus_req", 32'(lu.bus_req), 32'd0);
      check("rst.bus_addr", lu.bus_addr, 32'd0);
      check("rst.bus_lanes", 32'(lu.bus_lanes), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst.req_ready", 32'(lu.req_ready), 32'd1);

      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].addr, vecs[i].size, vecs[i].rdata, vecs[i].rerr,
                 vecs[i].gnt_dly, vecs[i].rv_dly, vecs[i].rdy_dly, 1'b0, o);
         $display("vec %0d addr=%08h size=%03b data=%08h mis=%0b err=%0b lat=%0d",
                  i, vecs[i].addr, vecs[i].size, o.data, o.mis, o.err, o.lat);
         compare($sformatf("vec%0d", i), o, vecs[i].e);
         @(posedge clk); #1;
      end

      // Reset pulsed while the bus read is outstanding
      lu.req_valid = 1'b1; lu.req_addr = 32'h600; lu.req_size = 3'b010;
      @(posedge clk); #1;
      lu.req_valid = 1'b0;
      check("rstmid.bus_req_addr_phase", 32'(lu.bus_req), 32'd1);
      lu.bus_gnt = 1'b1;
      @(posedge clk); #1;
      lu.bus_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstmid.bus_req", 32'(lu.bus_req), 32'd0);
      check("rstmid.resp_valid", 32'(lu.resp_valid), 32'd0);
      check("rstmid.bus_lanes", 32'(lu.bus_lanes), 32'd0);
      check("rstmid.req_ready", 32'(lu.req_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lu.bus_rvalid = 1'b1; lu.bus_rdata = 32'hDEAD_BEEF;
      quiet = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         lu.bus_rvalid = 1'b0;
         if (lu.resp_valid !== 1'b0 || lu.req_ready !== 1'b1) quiet = 1'b0;
      end
      check("rstmid.stray_rvalid_ignored", 32'(quiet), 32'd1);
      $display("reset-in-flight sequence quiet=%0b", quiet);
      e = model(32'h604, 3'b010, 32'hCAFE_F00D, 1'b0, 0, 0);
      run_txn(32'h604, 3'b010, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 1'b0, o);
      $display("post-reset LW data=%08h lat=%0d", o.data, o.lat);
      compare("post_reset", o, e);

      // Randomized loads against the reference model
      for (int n = 0; n < 40; n++) begin
         logic [31:0] addr, rdata;
         logic [2:0]  size;
         logic        rerr;
         int          gd, rv, rd, pick;
         addr  = $urandom;
         size  = 3'($urandom);
         rdata = $urandom;
         rerr  = ($urandom_range(0, 7) == 0);
         gd    = $urandom_range(0, 3);
         pick  = $urandom_range(0, 9);
         rv    = (pick < 7) ? $urandom_range(0, 4) : (pick == 7) ? TIMEOUT - 1 : -1;
         rd    = $urandom_range(0, 3);
         e = model(addr, size, rdata, rerr, gd, rv);
         run_txn(addr, size, rdata, rerr, gd, rv, rd, 1'($urandom), o);
         $display("rnd %0d addr=%08h size=%03b data=%08h mis=%0b err=%0b lat=%0d",
                  n, addr, size, o.data, o.mis, o.err, o.lat);
         compare($sformatf("rnd%0d", n), o, e);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
